// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU slice:
//   - WIDTH_DEF : default datapath width (matches the register file word)
//   - OP_*      : 4-bit operation codes sampled with start
//   - state_t   : sequencer FSM encoding (IDLE / MUL / DONE)
//   - is_single_op() : true for op codes that complete in one cycle
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 0..9 are the single-cycle group; MUL and 11..15 are handled apart.
  function automatic logic is_single_op(input logic [3:0] code);
    return (code <= OP_SLTU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears all state)
//   load      : latch a (multiplicand) and b (multiplier), clear acc/counter
//   step      : perform one shift-add iteration
//   a, b      : operands, sampled only on load
//   product   : running accumulator; final once MUL_CYCLES steps are done
//   finished  : high while the counter sits on the final iteration, i.e. the
//               step taken in this cycle completes the product
module alu_mul_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             finished
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;

  // Bits shifted past the top of mcand only affect product bits above
  // WIDTH, so dropping them keeps the low word exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  assign product  = acc;
  assign finished = (count == CNT_W'(MUL_CYCLES - 1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Execute stage: single-cycle logic/arith/shift/compare ops plus an
// iterative MUL, with a start/busy/done handshake for the control sequencer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, only honoured in IDLE
//   op       : operation code, sampled with start
//   alu_in   : operand A from the register file ALU read port
//   sbus_in  : operand B from the system bus (register value or immediate)
//   result   : registered result, held until the next accepted op completes
//   done     : one-cycle pulse when result is updated
//   busy     : high while a MUL is in flight
//   zero     : registered, high when result == 0
//   illegal  : registered, high if the last completed op code was undefined
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] sbus_in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  state_t state;
  state_t state_next;

  logic accept_single;
  logic accept_illegal;
  logic accept_mul;
  logic mul_step;
  logic mul_commit;
  logic mul_finished;

  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] mul_product;
  logic [SH_W-1:0]  shamt;

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_mul),
    .step     (mul_step),
    .a        (alu_in),
    .b        (sbus_in),
    .product  (mul_product),
    .finished (mul_finished)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is only looked at in IDLE; anything arriving during MUL or DONE
  // is dropped so the sequencer has to wait for done.
  always_comb begin
    state_next     = state;
    accept_single  = 1'b0;
    accept_illegal = 1'b0;
    accept_mul     = 1'b0;
    mul_step       = 1'b0;
    mul_commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            accept_mul = 1'b1;
            state_next = ST_MUL;
          end else if (is_single_op(op)) begin
            accept_single = 1'b1;
          end else begin
            accept_illegal = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_finished) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        mul_commit = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Single-cycle operation mux; shift amount is the low log2(WIDTH) bits of B.
  always_comb begin
    shamt      = sbus_in[SH_W-1:0];
    single_res = '0;
    case (op)
      OP_ADD:  single_res = alu_in + sbus_in;
      OP_SUB:  single_res = alu_in - sbus_in;
      OP_AND:  single_res = alu_in & sbus_in;
      OP_OR:   single_res = alu_in | sbus_in;
      OP_XOR:  single_res = alu_in ^ sbus_in;
      OP_SLL:  single_res = alu_in << shamt;
      OP_SRL:  single_res = alu_in >> shamt;
      OP_SRA:  single_res = $signed(alu_in) >>> shamt;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(alu_in) < $signed(sbus_in))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (alu_in < sbus_in)};
      default: single_res = '0;
    endcase
  end

  // Result-side registers. For MUL, result/zero/illegal only move when the
  // product is committed, so they stay stable between done pulses; busy
  // drops on the same edge that raises done so the two never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_single) begin
        result  <= single_res;
        zero    <= (single_res == '0);
        illegal <= 1'b0;
        done    <= 1'b1;
      end else if (accept_illegal) begin
        result  <= '0;
        zero    <= 1'b1;
        illegal <= 1'b1;
        done    <= 1'b1;
      end else if (accept_mul) begin
        busy <= 1'b1;
      end else if (mul_commit) begin
        result  <= mul_product;
        zero    <= (mul_product == '0);
        illegal <= 1'b0;
        done    <= 1'b1;
        busy    <= 1'b0;
      end
    end
  end

endmodule
